ripple_carry_adder: RTL and testbench



---
 rtl/ripple_carry_adder.sv | 72 +++++++
 tb/tb_ripple_carry_adder.sv | 119 +++++++++++
 2 files changed

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
// Sum, carry-out and signed overflow are registered on the rising edge.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module ripple_carry_adder (
  input  logic clk,
  input  logic rst,
  input  logic A_1,
  input  logic A_2,
  input  logic A_3,
  input  logic A_4,
  input  logic B_1,
  input  logic B_2,
  input  logic B_3,
  input  logic B_4,
  input  logic Cin,
  output logic S_1,
  output logic S_2,
  output logic S_3,
  output logic S_4,
  output logic Cout,
  output logic Ovf
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] s;
  logic [4:0] c;

  assign a    = {A_4, A_3, A_2, A_1};
  assign b    = {B_4, B_3, B_2, B_1};
  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_cell
    full_adder_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk) begin
    if (rst) begin
      {S_4, S_3, S_2, S_1} <= 4'b0000;
      Cout                 <= 1'b0;
      Ovf                  <= 1'b0;
    end else begin
      {S_4, S_3, S_2, S_1} <= s;
      Cout                 <= c[4];
      Ovf                  <= c[3] ^ c[4];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Bench for ripple_carry_adder: directed cases, overflow corners,
// exhaustive back-to-back sweep with a mid-stream reset.

module tb_ripple_carry_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a_v = 4'd0;
  logic [3:0] b_v = 4'd0;
  logic       ci_v = 1'b0;
  logic       S_1, S_2, S_3, S_4, Cout, Ovf;

  int errors = 0;
  int checks = 0;

  logic [5:0] sb_q[$];

  always #5 clk = ~clk;

  ripple_carry_adder dut (
    .clk  (clk),
    .rst  (rst),
    .A_1  (a_v[0]),
    .A_2  (a_v[1]),
    .A_3  (a_v[2]),
    .A_4  (a_v[3]),
    .B_1  (b_v[0]),
    .B_2  (b_v[1]),
    .B_3  (b_v[2]),
    .B_4  (b_v[3]),
    .Cin  (ci_v),
    .S_1  (S_1),
    .S_2  (S_2),
    .S_3  (S_3),
    .S_4  (S_4),
    .Cout (Cout),
    .Ovf  (Ovf)
  );

  // Expected word is {ovf, cout, sum[3:0]}
  function automatic logic [5:0] model(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci,
    input logic       r
  );
    int         u;
    int         sa;
    int         sb;
    int         sv;
    logic       ov;
    logic [4:0] u5;
    if (r) return 6'b0;
    u  = int'(a) + int'(b) + int'(ci);
    u5 = u[4:0];
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    sv = sa + sb + int'(ci);
    ov = (sv > 7) || (sv < -8);
    return {ov, u5};
  endfunction

  task automatic step(
    input string      tag,
    input logic       r,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci
  );
    logic [5:0] obs;
    logic [5:0] exp;
    rst  = r;
    a_v  = a;
    b_v  = b;
    ci_v = ci;
    sb_q.push_back(model(a, b, ci, r));
    @(posedge clk);
    #1;
    obs = {Ovf, Cout, S_4, S_3, S_2, S_1};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty obs=%b", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s a=%b b=%b ci=%b obs=%b exp=%b",
               tag, a, b, ci, obs, exp);
      end
    end
  endtask

  initial begin
    step("reset",      1'b1, 4'b1111, 4'b1111, 1'b1);
    step("rst_rel",    1'b0, 4'b1111, 4'b1111, 1'b1);
    step("zero",       1'b0, 4'b0000, 4'b0000, 1'b0);
    step("pass_b",     1'b0, 4'b0000, 4'b1111, 1'b0);
    step("pass_a",     1'b0, 4'b1111, 4'b0000, 1'b0);
    step("ripple_ff",  1'b0, 4'b1111, 4'b1111, 1'b0);
    step("ripple_b",   1'b0, 4'b0000, 4'b1111, 1'b1);
    step("ripple_a",   1'b0, 4'b1111, 4'b0000, 1'b1);
    step("cin_only",   1'b0, 4'b0000, 4'b0000, 1'b1);
    step("ovf_pos",    1'b0, 4'b0111, 4'b0001, 1'b0);
    step("ovf_neg",    1'b0, 4'b1000, 4'b1000, 1'b0);
    step("mixed",      1'b0, 4'b0101, 4'b1010, 1'b1);
    for (int i = 0; i < 512; i++) begin
      if (i == 300) begin
        step("mid_reset", 1'b1, i[3:0], i[7:4], i[8]);
      end
      step("sweep", 1'b0, i[3:0], i[7:4], i[8]);
    end
    step("hold_rst",   1'b1, 4'b0111, 4'b0111, 1'b1);
    step("after_rst",  1'b0, 4'b0111, 4'b0111, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
